// File: rtl/normalize_stream_if.sv
// Pixel-in / normalized-value-out stream bundle for normalize_stream.
interface normalize_stream_if #(
   parameter int unsigned IN_W  = 8,
   parameter int unsigned OUT_W = 16,
   parameter int unsigned CH_W  = 2
);
   logic [IN_W-1:0]         in_data;
   logic                    in_valid;
   logic                    in_sof;
   logic                    in_ready;
   logic signed [OUT_W-1:0] out_data;
   logic [CH_W-1:0]         out_ch;
   logic                    out_last;
   logic                    out_valid;
   logic                    out_ready;

   // Block side: consumes pixels, produces normalized beats.
   modport slave (
      input  in_data, in_valid, in_sof, out_ready,
      output in_ready, out_data, out_ch, out_last, out_valid
   );

   // Environment side: sources pixels, sinks normalized beats.
   modport master (
      output in_data, in_valid, in_sof, out_ready,
      input  in_ready, out_data, out_ch, out_last, out_valid
   );
endinterface

// File: rtl/normalize_stream.sv
// Per-channel mean subtraction and scaling of an interleaved pixel stream,
// rounded half-up and saturated to a signed fixed-point output.
module normalize_stream #(
   parameter  int unsigned IN_W    = 8,
   parameter  int unsigned OUT_W   = 16,
   parameter  int unsigned CH      = 3,
   parameter  int unsigned SCALE_W = 16,
   parameter  int unsigned SHIFT   = 4,
   localparam int unsigned CH_W    = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic                clk,
   input  logic                rst,
   normalize_stream_if.slave   stream,
   input  logic                cfg_we,
   input  logic                cfg_sel,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [SCALE_W-1:0]  cfg_data,
   output logic [15:0]         sat_cnt
);

   localparam int unsigned DIFF_W = IN_W + 1;
   localparam int unsigned PROD_W = DIFF_W + SCALE_W;
   localparam int unsigned SUM_W  = PROD_W + 1;
   localparam int unsigned EXT_W  = (SUM_W > OUT_W) ? SUM_W : OUT_W + 1;

   localparam logic signed [SCALE_W-1:0] SCALE_RST = SCALE_W'(128 << SHIFT);
   localparam logic signed [SUM_W-1:0]   RND_ADD   = SUM_W'((2 ** SHIFT) / 2);
   localparam logic signed [EXT_W-1:0]   SAT_MAX   =
      {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [EXT_W-1:0]   SAT_MIN   =
      {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
   localparam logic [CH_W-1:0]           CH_LAST   = CH_W'(CH - 1);

   logic [IN_W-1:0]            offset_q [CH];
   logic signed [SCALE_W-1:0]  scale_q  [CH];

   logic [CH_W-1:0]            cnt_q, cnt_d;
   logic                       s1_valid_q;
   logic [CH_W-1:0]            s1_ch_q;
   logic signed [PROD_W-1:0]   s1_prod_q;

   logic                       out_valid_q;
   logic signed [OUT_W-1:0]    out_data_q;
   logic [CH_W-1:0]            out_ch_q;
   logic                       out_last_q;
   logic [15:0]                sat_cnt_q, sat_cnt_d;

   logic                       en_c, accept_c, cfg_hit_c, sat_c;
   logic [CH_W-1:0]            tag_c;
   logic signed [DIFF_W-1:0]   diff_c;
   logic signed [PROD_W-1:0]   prod_c;
   logic signed [SUM_W-1:0]    sum_c;
   logic signed [EXT_W-1:0]    rnd_c;
   logic signed [OUT_W-1:0]    res_c;

   // Handshake, channel tagging, stage-1 product and stage-2 round/saturate.
   always_comb begin
      en_c      = ~out_valid_q | stream.out_ready;
      accept_c  = stream.in_valid & en_c;
      cfg_hit_c = cfg_we & (32'(cfg_ch) < CH);
      tag_c     = stream.in_sof ? '0 : cnt_q;

      cnt_d = cnt_q;
      if (accept_c) begin
         cnt_d = (tag_c == CH_LAST) ? '0 : tag_c + CH_W'(1);
      end

      diff_c = $signed({1'b0, stream.in_data}) - $signed({1'b0, offset_q[tag_c]});
      prod_c = PROD_W'(diff_c) * PROD_W'(scale_q[tag_c]);

      sum_c = SUM_W'(s1_prod_q) + RND_ADD;
      rnd_c = EXT_W'(sum_c >>> SHIFT);
      sat_c = (rnd_c > SAT_MAX) || (rnd_c < SAT_MIN);
      if (rnd_c > SAT_MAX) begin
         res_c = OUT_W'(SAT_MAX);
      end else if (rnd_c < SAT_MIN) begin
         res_c = OUT_W'(SAT_MIN);
      end else begin
         res_c = OUT_W'(rnd_c);
      end

      sat_cnt_d = sat_cnt_q;
      if (en_c && s1_valid_q && sat_c && (sat_cnt_q != 16'hFFFF)) begin
         sat_cnt_d = sat_cnt_q + 16'd1;
      end
   end

   // Per-channel offset/scale tables; out-of-range channel writes are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(CH); i++) begin
            offset_q[i] <= '0;
            scale_q[i]  <= SCALE_RST;
         end
      end else if (cfg_hit_c) begin
         if (cfg_sel) begin
            scale_q[cfg_ch] <= cfg_data;
         end else begin
            offset_q[cfg_ch] <= cfg_data[IN_W-1:0];
         end
      end
   end

   // Two-stage pipeline advancing in lockstep whenever the output can move.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         s1_valid_q  <= 1'b0;
         s1_ch_q     <= '0;
         s1_prod_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_last_q  <= 1'b0;
         sat_cnt_q   <= '0;
      end else begin
         cnt_q     <= cnt_d;
         sat_cnt_q <= sat_cnt_d;
         if (en_c) begin
            s1_valid_q  <= accept_c;
            s1_ch_q     <= tag_c;
            s1_prod_q   <= prod_c;
            out_valid_q <= s1_valid_q;
            out_data_q  <= res_c;
            out_ch_q    <= s1_ch_q;
            out_last_q  <= (s1_ch_q == CH_LAST);
         end
      end
   end

   assign stream.in_ready  = en_c;
   assign stream.out_valid = out_valid_q;
   assign stream.out_data  = out_data_q;
   assign stream.out_ch    = out_ch_q;
   assign stream.out_last  = out_last_q;
   assign sat_cnt          = sat_cnt_q;

endmodule

// File: tb/tb_normalize_stream.sv
// Randomized and directed checks of normalize_stream against a transaction-level model.
module tb_normalize_stream;

   localparam int unsigned IN_W    = 8;
   localparam int unsigned OUT_W   = 16;
   localparam int unsigned CH      = 3;
   localparam int unsigned SCALE_W = 16;
   localparam int unsigned SHIFT   = 4;
   localparam int unsigned CH_W    = (CH > 1) ? $clog2(CH) : 1;

   logic               clk = 1'b0;
   logic               rst;
   logic               cfg_we;
   logic               cfg_sel;
   logic [CH_W-1:0]    cfg_ch;
   logic [SCALE_W-1:0] cfg_data;
   logic [15:0]        sat_cnt;

   always #5 clk = ~clk;

   normalize_stream_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CH_W(CH_W)) s ();

   normalize_stream #(
      .IN_W(IN_W), .OUT_W(OUT_W), .CH(CH), .SCALE_W(SCALE_W), .SHIFT(SHIFT)
   ) dut (
      .clk(clk), .rst(rst), .stream(s),
      .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_ch(cfg_ch), .cfg_data(cfg_data),
      .sat_cnt(sat_cnt)
   );

   typedef struct {
      int data;
      int ch;
      int last;
      int sat;
      bit dir;
      int dexp;
   } exp_t;

   exp_t   sb[$];
   int     off_m [CH];
   int     scl_m [CH];
   int     cnt_m;
   int     sat_m;
   int     n_vec = 0;
   int     n_err = 0;
   bit     ov_seen, acc_seen;
   bit     pv, pr;
   longint pd;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference arithmetic: integer math on the rules, floor-shift for rounding.
   function automatic int model_out(input int d, input int c, output bit sat);
      longint diff, prod, add, rnd, maxv, minv;
      diff = longint'(d) - longint'(off_m[c]);
      prod = diff * longint'(scl_m[c]);
      add  = (SHIFT > 0) ? (longint'(1) <<< (SHIFT - 1)) : 0;
      rnd  = (prod + add) >>> SHIFT;
      maxv = (longint'(1) <<< (OUT_W - 1)) - 1;
      minv = -(longint'(1) <<< (OUT_W - 1));
      sat  = (rnd > maxv) || (rnd < minv);
      if (rnd > maxv) rnd = maxv;
      if (rnd < minv) rnd = minv;
      return int'(rnd);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < int'(CH); i++) begin
         off_m[i] = 0;
         scl_m[i] = 128 << SHIFT;
      end
      cnt_m = 0;
      sat_m = 0;
      sb.delete();
      pv = 1'b0;
   endtask

   // One clock: drive at negedge, sample just after, update model for the next edge.
   task automatic cyc(input bit v, input int d, input bit sof, input bit ordy,
                      input bit we = 0, input bit sel = 0, input int cch = 0,
                      input int cdat = 0, input bit dir = 0, input int dexp = 0);
      exp_t e;
      bit   sat;
      int   tag;
      logic signed [SCALE_W-1:0] sc;
      @(negedge clk);
      rst         = 1'b0;
      s.in_valid  = v;
      s.in_data   = IN_W'(d);
      s.in_sof    = sof;
      s.out_ready = ordy;
      cfg_we      = we;
      cfg_sel     = sel;
      cfg_ch      = CH_W'(cch);
      cfg_data    = SCALE_W'(cdat);
      #1;
      ov_seen = s.out_valid;
      if (pv && !pr) check("hold_data", s.out_data, pd);
      check("in_ready", s.in_ready, !s.out_valid || s.out_ready);
      if (s.out_valid && s.out_ready) begin
         if (sb.size() == 0) begin
            check("spurious_out", 1, 0);
         end else begin
            e = sb.pop_front();
            check("out_data", s.out_data, e.data);
            check("out_ch", s.out_ch, e.ch);
            check("out_last", s.out_last, e.last);
            check("sat_cnt", sat_cnt, e.sat);
            if (e.dir) check("directed", s.out_data, e.dexp);
         end
      end
      acc_seen = v && s.in_ready;
      if (acc_seen) begin
         tag    = sof ? 0 : cnt_m;
         e.data = model_out(d, tag, sat);
         if (sat && sat_m < 65535) sat_m++;
         e.ch   = tag;
         e.last = (tag == int'(CH) - 1) ? 1 : 0;
         e.sat  = sat_m;
         e.dir  = dir;
         e.dexp = dexp;
         sb.push_back(e);
         cnt_m  = (tag + 1) % int'(CH);
      end
      if (we && cch < int'(CH)) begin
         if (sel) begin
            sc = SCALE_W'(cdat);
            scl_m[cch] = int'(sc);
         end else begin
            off_m[cch] = cdat % (1 << IN_W);
         end
      end
      pv = s.out_valid;
      pr = s.out_ready;
      pd = s.out_data;
   endtask

   task automatic wr_cfg(input bit sel, input int cch, input int cdat);
      cyc(0, 0, 0, 1, 1, sel, cch, cdat);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() > 0; i++) cyc(0, 0, 0, 1);
      check("drain_left", sb.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; s.in_valid = 1'b0; s.in_sof = 1'b0; s.out_ready = 1'b1; cfg_we = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", s.out_valid, 0);
      check("rst_out_data", s.out_data, 0);
      check("rst_out_ch", s.out_ch, 0);
      check("rst_out_last", s.out_last, 0);
      check("rst_sat_cnt", sat_cnt, 0);
      model_reset();
   endtask

   initial begin
      int idx, k;
      rst = 1'b1; s.in_valid = 1'b0; s.in_data = '0; s.in_sof = 1'b0; s.out_ready = 1'b1;
      cfg_we = 1'b0; cfg_sel = 1'b0; cfg_ch = '0; cfg_data = '0;
      do_reset();

      // Legacy default: pixel x 128, two-cycle latency, running channel tags.
      cyc(1, 255, 1, 1, 0, 0, 0, 0, 1, 32640);
      cyc(0, 0, 0, 1);
      check("lat_s1_empty", ov_seen, 0);
      cyc(0, 0, 0, 1);
      check("lat_s2_valid", ov_seen, 1);
      cyc(1, 10, 0, 1);
      cyc(1, 20, 0, 1);
      drain();

      // Channel 1 mean subtraction.
      wr_cfg(0, 1, 128);
      wr_cfg(1, 1, 2048);
      cyc(1, 3, 1, 1);
      cyc(1, 0, 0, 1, 0, 0, 0, 0, 1, -16384);
      cyc(1, 3, 1, 1);
      cyc(1, 255, 0, 1, 0, 0, 0, 0, 1, 16256);
      drain();

      // Round half-up, including negative ties.
      wr_cfg(1, 0, 1);
      cyc(1, 8, 1, 1, 0, 0, 0, 0, 1, 1);
      cyc(1, 7, 1, 1, 0, 0, 0, 0, 1, 0);
      wr_cfg(0, 0, 16);
      cyc(1, 8, 1, 1, 0, 0, 0, 0, 1, 0);
      cyc(1, 7, 1, 1, 0, 0, 0, 0, 1, -1);
      drain();

      // Saturation at both rails.
      do_reset();
      wr_cfg(1, 0, 32767);
      cyc(1, 255, 1, 1, 0, 0, 0, 0, 1, 32767);
      drain();
      check("sat_cnt_pos", sat_cnt, 1);
      wr_cfg(1, 0, 32'h8000);
      cyc(1, 255, 1, 1, 0, 0, 0, 0, 1, -32768);
      drain();
      check("sat_cnt_neg", sat_cnt, 2);

      // Backpressure mid-stream: six beats, three stalled cycles.
      idx = 0;
      k   = 0;
      while (idx < 6 && k < 40) begin
         cyc(1, 40 * idx + 5, idx == 0, !(k >= 2 && k < 5));
         if (acc_seen) idx++;
         k++;
      end
      check("bp_accepted", idx, 6);
      drain();

      // Reset with two beats in flight.
      wr_cfg(1, 0, 100);
      cyc(1, 50, 1, 1);
      cyc(1, 60, 0, 1);
      do_reset();
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
      cyc(1, 1, 0, 1, 0, 0, 0, 0, 1, 128);
      drain();

      // Randomized traffic with config churn and random backpressure.
      for (int i = 0; i < 2000; i++) begin
         cyc(($urandom_range(0, 99) < 70), $urandom_range(0, 255),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) < 70),
             ($urandom_range(0, 19) == 0), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 65535));
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/normalize_stream.md
Name: normalize_stream

Overview:
Parametrised successor to the Layer_1 pixel normalizer. It accepts a stream of unsigned CH-interleaved pixels and applies per-channel mean subtraction and per-channel scaling. The result is rounded and saturated to a signed OUT_W fixed-point value. It sits between the pixel source and the first convolution layer, adds ready/valid backpressure and channel tagging, and its reset-default configuration reproduces the legacy "pixel × 128" output.

Parameters:
IN_W, 8, unsigned input pixel width
OUT_W, 16, signed output width
CH, 3, interleaved channel count (≥1)
SCALE_W, 16, signed per-channel scale width
SHIFT, 4, right shift applied after multiply (≥0)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_data  in  IN_W  unsigned pixel
in_valid  in  1  input beat valid
in_sof  in  1  start of frame; forces this beat to channel 0
in_ready  out  1  block can accept a beat
out_data  out  OUT_W  signed normalized value
out_ch  out  $clog2(CH) (min 1)  channel tag of out_data
out_last  out  1  out_ch == CH-1
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
cfg_we  in  1  config write strobe
cfg_sel  in  1  0 = offset, 1 = scale
cfg_ch  in  $clog2(CH) (min 1)  target channel
cfg_data  in  SCALE_W  offset (low IN_W bits, unsigned) or scale (signed)
sat_cnt  out  16  saturation event counter

Behaviour:
- Reset (rst=1 at clk edge):
  - out_valid=0, out_data=0, out_ch=0, out_last=0.
  - All internal stage valids=0; channel counter=0; sat_cnt=0.
  - All offsets=0; all scales=128<<SHIFT (2048 by default).
  - Reset mid-operation discards all in-flight beats; nothing is emitted afterwards.
- Pipeline, two register stages moving together:
  - en = ~out_valid | out_ready; in_ready = en (combinational from out_ready/out_valid).
  - Accept = in_valid & in_ready.
  - S1 on en: capture valid=Accept, channel tag, product.
  - S2 on en: capture rounded/saturated result into out_*.
  - Latency 2 cycles from accept to out_valid when unstalled; full throughput 1 beat/cycle.
  - While en=0, all stage registers and outputs hold stable; no beat is lost or duplicated.
  - Bubbles are not collapsed.
- Channel counter:
  - The tag for an accepted beat is 0 if in_sof=1, else the counter value.
  - After each accept the counter becomes tag+1, wrapping CH-1 → 0.
  - CH=1: tag is always 0 and out_last is always 1.
- Arithmetic, per beat with tag c:
  - diff = {0,in_data} − {0,offset[c]}, signed IN_W+1 bits.
  - prod = diff × scale[c], signed IN_W+1+SCALE_W bits, no overflow.
  - rnd = (prod + (SHIFT>0 ? 2^(SHIFT−1) : 0)) >>> SHIFT. This is round-half-up (toward +∞ on ties), in full precision.
  - Saturate rnd to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- Saturation counter:
  - When a saturating beat enters S2, sat_cnt increments by 1.
  - It sticks at 0xFFFF and is cleared only by rst.
- Config:
  - cfg_we writes offset[cfg_ch] (cfg_data[IN_W-1:0]) or scale[cfg_ch] (cfg_data), and takes effect at the next edge.
  - A beat accepted in the same cycle as a write to its channel uses the old value.
  - A write with cfg_ch ≥ CH is ignored.
  - Writes are allowed while stalled; a beat already in S1 is unaffected.

Test Plan:
- Reset defaults, in_data=255 accepted with in_sof=1 → 2 cycles later out_data=32640, out_ch=0, out_last=0; next two beats tagged 1, 2; third beat has out_last=1.
- Program ch1 offset=128, scale=2048; send in_data=0 on ch1 → out_data=−16384; in_data=255 → out_data=16256.
- Rounding, ch0 scale=1, offset=0: in=8 → 1; in=7 → 0; with offset=16, in=8 → 0, in=7 → −1.
- Saturation, ch0 scale=32767, in=255 → out_data=32767, sat_cnt=1; ch0 scale=−32768, in=255 → −32768, sat_cnt=2.
- Backpressure: stream 6 beats, out_ready=0 for 3 cycles mid-stream → in_ready=0, out_data held, all 6 beats emitted in order with correct tags.
- Assert rst with 2 beats in flight → next cycle out_valid=0, no beats emitted afterwards; the following beat is tagged 0; scales read back to default via output (in=1 → 128).
